iob_2p_mem_pipe: RTL and testbench
==================================

IOB_2P_MEM_PIPE -- requirements
Module: iob_2p_mem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 6: address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 w_en  input  1  write enable.
REQ-008 w_strb  input  DATA_W/8  per-byte write strobe; bit i covers w_data[8i+7:8i].
REQ-009 w_addr  input  ADDR_W  write address.
REQ-010 w_data  input  DATA_W  write data.
REQ-011 r_en  input  1  read request.
REQ-012 r_addr  input  ADDR_W  read address.
REQ-013 r_data  output  DATA_W  registered read data.
REQ-014 r_valid  output  1  one-cycle pulse marking r_data as the result of a read.

Function
REQ-015 Writes SHALL occur at the rising edge when w_en=1 and rst=0: strobed bytes take w_data, unstrobed bytes keep their value; w_en=1 with w_strb=0 SHALL change nothing.
REQ-016 A read with r_en=1 sampled at edge N SHALL present data at r_data with r_valid=1 after edge N+RD_LAT-1 (RD_LAT=1: visible in the cycle after the request).
REQ-017 Reads SHALL be fully pipelined: r_en held high for K cycles SHALL yield K consecutive r_valid pulses, in request order.
REQ-018 With no read completing, r_valid SHALL be 0 and r_data SHALL hold its last value.
REQ-019 Read and write to different addresses in the same cycle SHALL be independent.
REQ-020 Read and write to the same address in the same cycle SHALL return the pre-write word, unless IOB_2P_MEM_BYPASS_EN is defined (REQ-026).
REQ-021 RD_LAT outside {1,2}, or DATA_W not a multiple of 8, SHALL cause an elaboration-time error.

Reset
REQ-022 While rst=1: r_valid=0, r_data=0, all pipeline valid and data registers cleared; w_en and r_en ignored.
REQ-023 Memory array contents SHALL NOT be reset; they are undefined until written.
REQ-024 Reset asserted with reads in flight SHALL drop them: no r_valid pulse for those requests after rst deasserts.
REQ-025 The first request accepted SHALL be the one sampled at the first edge with rst=0.

Configuration
REQ-026 Macro IOB_2P_MEM_BYPASS_EN: when defined, a same-cycle same-address read SHALL return the merged word (strobed bytes from w_data, other bytes from the array) with unchanged latency. When undefined, no forwarding logic SHALL exist and REQ-020 read-first behaviour applies.

Structure
REQ-027 Package iob_2p_mem_pkg SHALL hold STRB_W = DATA_W/8, the legal RD_LAT constants, and the byte-merge function shared by the write path and the bypass path.
REQ-028 Sub-module iob_2p_mem_rd_pipe SHALL implement the second output stage (data and valid registers with synchronous reset), instantiated only when RD_LAT=2.

Verification
REQ-029 Byte write: write 0xAABBCCDD to addr 3 (strb=0xF), then write 0x11223344 to addr 3 with strb=0x5 -> a read of addr 3 returns 0xAA22CC44.
REQ-030 Latency: RD_LAT=2, r_en=1 with r_addr=5 at edge N -> r_valid=1 and r_data=mem[5] after edge N+1 only; r_valid=0 elsewhere.
REQ-031 Streaming: addrs 0..7 preloaded with 0x100+addr, r_en high for 8 cycles -> 8 consecutive r_valid pulses with data 0x100..0x107 in order.
REQ-032 Collision: addr 9 holds 0x0; same cycle write 0xFFFFFFFF (strb=0xF) and read addr 9 -> r_data=0x0 without the macro, 0xFFFFFFFF with IOB_2P_MEM_BYPASS_EN.
REQ-033 Reset mid-flight: RD_LAT=2, issue a read, assert rst on the next edge -> no r_valid pulse, r_data=0; memory contents are unchanged after rst deasserts.
REQ-034 Null write: w_en=1 and w_strb=0 to addr 2 holding 0x12345678 -> a read returns 0x12345678.

Source files
------------

// File: rtl/iob_2p_mem_pkg.sv
// Shared constants and byte-merge helper for the two-port pipelined memory.
// Used by the write path and by the optional IOB_2P_MEM_BYPASS_EN forwarding path.
package iob_2p_mem_pkg;

    localparam int unsigned RD_LAT_1 = 1;
    localparam int unsigned RD_LAT_2 = 2;

    // Upper bound for the width-generic merge helper; narrower words are zero-extended.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    function automatic int unsigned strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        for (int i = 0; i < int'(MAX_STRB_W); i++) begin
            res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_2p_mem_rd_pipe.sv
// Second read-output stage: data/valid registers with synchronous reset.
// Data only loads on a valid beat so r_data holds between reads.
module iob_2p_mem_rd_pipe #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/iob_2p_mem_pipe.sv
// Two-port (1W/1R) byte-strobed memory with 1- or 2-cycle pipelined reads.
// Define IOB_2P_MEM_BYPASS_EN to forward same-cycle same-address writes to the read port.
module iob_2p_mem_pipe
    import iob_2p_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_en,
    input  logic [strb_w(DATA_W)-1:0] w_strb,
    input  logic [ADDR_W-1:0]         w_addr,
    input  logic [DATA_W-1:0]         w_data,
    input  logic                      r_en,
    input  logic [ADDR_W-1:0]         r_addr,
    output logic [DATA_W-1:0]         r_data,
    output logic                      r_valid
);

    localparam int unsigned STRB_W = strb_w(DATA_W);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    if (RD_LAT != RD_LAT_1 && RD_LAT != RD_LAT_2) begin : g_bad_lat
        $error("iob_2p_mem_pipe: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % 8) != 0 || DATA_W == 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("iob_2p_mem_pipe: DATA_W must be a non-zero multiple of 8 within MAX_DATA_W");
    end

    // Array is deliberately not reset.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic              rd1_valid_q;
    logic [DATA_W-1:0] rd1_data_q;

    always_comb begin
        wr_word = DATA_W'(byte_merge(MAX_DATA_W'(mem[w_addr]), MAX_DATA_W'(w_data),
                                     MAX_STRB_W'(w_strb)));
    end

    always_ff @(posedge clk) begin
        if (!rst && w_en) begin
            mem[w_addr] <= wr_word;
        end
    end

`ifdef IOB_2P_MEM_BYPASS_EN
    always_comb begin
        rd_word = mem[r_addr];
        if (w_en && (w_addr == r_addr)) begin
            rd_word = DATA_W'(byte_merge(MAX_DATA_W'(mem[r_addr]), MAX_DATA_W'(w_data),
                                         MAX_STRB_W'(w_strb)));
        end
    end
`else
    // Read-first: the array read sees the pre-write word on a collision.
    always_comb begin
        rd_word = mem[r_addr];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_valid_q <= 1'b0;
            rd1_data_q  <= '0;
        end else begin
            rd1_valid_q <= r_en;
            if (r_en) begin
                rd1_data_q <= rd_word;
            end
        end
    end

    if (RD_LAT == RD_LAT_2) begin : g_lat2
        iob_2p_mem_rd_pipe #(
            .DATA_W (DATA_W)
        ) u_rd_pipe (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (rd1_valid_q),
            .in_data   (rd1_data_q),
            .out_valid (r_valid),
            .out_data  (r_data)
        );
    end else begin : g_lat1
        assign r_valid = rd1_valid_q;
        assign r_data  = rd1_data_q;
    end

    logic unused_strb_w;
    assign unused_strb_w = ^STRB_W;

endmodule

// File: tb/tb_iob_2p_mem_pipe.sv
// Directed bench: drives an RD_LAT=1 and an RD_LAT=2 instance with shared stimulus.
module tb_iob_2p_mem_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [3:0]  w_strb;
    logic [5:0]  w_addr;
    logic [31:0] w_data;
    logic        r_en;
    logic [5:0]  r_addr;
    logic [31:0] r_data1, r_data2;
    logic        r_valid1, r_valid2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_2p_mem_pipe #(.DATA_W(32), .ADDR_W(6), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr),
        .w_data(w_data), .r_en(r_en), .r_addr(r_addr), .r_data(r_data1), .r_valid(r_valid1)
    );

    iob_2p_mem_pipe #(.DATA_W(32), .ADDR_W(6), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr),
        .w_data(w_data), .r_en(r_en), .r_addr(r_addr), .r_data(r_data2), .r_valid(r_valid2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        w_en = 1'b1; w_addr = a; w_data = d; w_strb = s;
        tick();
        w_en = 1'b0; w_strb = 4'h0;
    endtask

    // Checks both instances' latency and data for one isolated read.
    task automatic do_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
        r_en = 1'b1; r_addr = a;
        tick();
        r_en = 1'b0;
        check({tag, " lat1 valid"}, {31'b0, r_valid1}, 32'd1);
        check({tag, " lat1 data"}, r_data1, exp);
        check({tag, " lat2 early valid"}, {31'b0, r_valid2}, 32'd0);
        tick();
        check({tag, " lat1 valid drop"}, {31'b0, r_valid1}, 32'd0);
        check({tag, " lat2 valid"}, {31'b0, r_valid2}, 32'd1);
        check({tag, " lat2 data"}, r_data2, exp);
        tick();
        check({tag, " lat2 valid drop"}, {31'b0, r_valid2}, 32'd0);
    endtask

    logic [31:0] exp_coll;

    initial begin
        rst = 1'b1; w_en = 1'b0; w_strb = 4'h0; w_addr = '0; w_data = '0;
        r_en = 1'b1; r_addr = '0;  // r_en must be ignored during reset
        repeat (3) tick();
        check("rst valid1", {31'b0, r_valid1}, 32'd0);
        check("rst data1", r_data1, 32'd0);
        check("rst valid2", {31'b0, r_valid2}, 32'd0);
        check("rst data2", r_data2, 32'd0);
        rst = 1'b0; r_en = 1'b0;
        tick();
        check("post-rst valid1", {31'b0, r_valid1}, 32'd0);
        tick();
        check("post-rst valid2", {31'b0, r_valid2}, 32'd0);

        // Byte strobes
        do_write(6'd3, 32'hAABBCCDD, 4'hF);
        do_write(6'd3, 32'h11223344, 4'h5);
        do_read("byte", 6'd3, 32'hAA22CC44);

        // Null write
        do_write(6'd2, 32'h12345678, 4'hF);
        do_write(6'd2, 32'hFFFFFFFF, 4'h0);
        do_read("null", 6'd2, 32'h12345678);

        // Streaming
        for (int i = 0; i < 8; i++) do_write(6'(i), 32'h100 + i, 4'hF);
        for (int k = 0; k <= 8; k++) begin
            r_en = (k < 8); r_addr = 6'(k);
            tick();
            if (k < 8) begin
                check($sformatf("stream lat1 valid %0d", k), {31'b0, r_valid1}, 32'd1);
                check($sformatf("stream lat1 data %0d", k), r_data1, 32'h100 + k);
            end else begin
                check("stream lat1 end", {31'b0, r_valid1}, 32'd0);
            end
            if (k >= 1) begin
                check($sformatf("stream lat2 valid %0d", k), {31'b0, r_valid2}, 32'd1);
                check($sformatf("stream lat2 data %0d", k), r_data2, 32'h100 + k - 1);
            end else begin
                check("stream lat2 start", {31'b0, r_valid2}, 32'd0);
            end
        end
        r_en = 1'b0;
        tick();
        check("hold valid2", {31'b0, r_valid2}, 32'd0);
        check("hold data1", r_data1, 32'h107);
        check("hold data2", r_data2, 32'h107);

        // Same-address collision
`ifdef IOB_2P_MEM_BYPASS_EN
        exp_coll = 32'hFFFFFFFF;
`else
        exp_coll = 32'h00000000;
`endif
        do_write(6'd9, 32'h0, 4'hF);
        w_en = 1'b1; w_addr = 6'd9; w_data = 32'hFFFFFFFF; w_strb = 4'hF;
        r_en = 1'b1; r_addr = 6'd9;
        tick();
        w_en = 1'b0; w_strb = 4'h0; r_en = 1'b0;
        check("coll lat1", r_data1, exp_coll);
        tick();
        check("coll lat2", r_data2, exp_coll);
        tick();
        do_read("coll after", 6'd9, 32'hFFFFFFFF);

        // Different-address read and write in the same cycle
        do_write(6'd20, 32'h5A5A5A5A, 4'hF);
        w_en = 1'b1; w_addr = 6'd21; w_data = 32'hCAFEF00D; w_strb = 4'hF;
        r_en = 1'b1; r_addr = 6'd20;
        tick();
        w_en = 1'b0; w_strb = 4'h0; r_en = 1'b0;
        check("indep lat1", r_data1, 32'h5A5A5A5A);
        tick();
        check("indep lat2", r_data2, 32'h5A5A5A5A);
        tick();
        do_read("indep wr", 6'd21, 32'hCAFEF00D);

        // Reset with a read in flight
        r_en = 1'b1; r_addr = 6'd5;
        tick();
        r_en = 1'b0; rst = 1'b1;
        check("mid lat1 valid", {31'b0, r_valid1}, 32'd1);
        tick();
        check("mid lat2 valid", {31'b0, r_valid2}, 32'd0);
        check("mid lat2 data", r_data2, 32'd0);
        check("mid lat1 data", r_data1, 32'd0);
        rst = 1'b0;
        tick();
        check("mid after valid2", {31'b0, r_valid2}, 32'd0);
        check("mid after data2", r_data2, 32'd0);
        tick();
        do_read("mid mem", 6'd5, 32'h105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
